// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, multi-cycle mul/div
// freezes and halt/resume. Enables and clears are combinational; counters saturate.
module pipe_hazard_ctrl #(
  parameter int REGW       = 5,
  parameter int MULDIV_CYC = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_memread,
  input  logic            ex_muldiv,
  input  logic            ex_halt,
  input  logic            br_taken,
  input  logic            resume,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            idex_en,
  output logic            ifid_clr,
  output logic            idex_clr,
  output logic            exmem_clr,
  output logic            halted,
  output logic [15:0]     stall_cnt,
  output logic [15:0]     flush_cnt
);

  typedef enum logic [1:0] {S_RUN, S_MULDIV, S_HALT} state_t;

  // The first freeze cycle happens in RUN, so MULDIV only needs MULDIV_CYC-2 more.
  localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYC - 2);

  state_t      state_q, state_d;
  logic [3:0]  md_cnt_q, md_cnt_d;
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        load_use;
  logic        flush_ev;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    idex_en   = 1'b1;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    exmem_clr = 1'b0;
    halted    = 1'b0;
    flush_ev  = 1'b0;
    state_d   = state_q;
    md_cnt_d  = md_cnt_q;
    if (!rst_n) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      exmem_clr = 1'b1;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (ex_muldiv) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_clr = 1'b1;
            md_cnt_d  = MD_LOAD;
            state_d   = S_MULDIV;
          end else begin
            if (br_taken) begin
              ifid_clr = 1'b1;
              idex_clr = 1'b1;
              flush_ev = 1'b1;
            end else if (load_use) begin
              pc_en    = 1'b0;
              ifid_en  = 1'b0;
              idex_clr = 1'b1;
            end
            if (ex_halt) state_d = S_HALT;
          end
        end
        S_MULDIV: begin
          if (md_cnt_q != 4'd0) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_clr = 1'b1;
            md_cnt_d  = md_cnt_q - 4'd1;
          end else begin
            state_d = S_RUN;
          end
        end
        S_HALT: begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          idex_en = 1'b0;
          halted  = 1'b1;
          if (resume) state_d = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      if (!pc_en)   stall_cnt_q <= sat_inc(stall_cnt_q);
      if (flush_ev) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;
  localparam int REGW       = 5;
  localparam int MULDIV_CYC = 4;

  localparam logic [6:0] O_DEF = 7'b111_000_0;
  localparam logic [6:0] O_FRZ = 7'b000_001_0;
  localparam logic [6:0] O_LU  = 7'b001_010_0;
  localparam logic [6:0] O_BR  = 7'b111_110_0;
  localparam logic [6:0] O_HLT = 7'b000_000_1;
  localparam logic [6:0] O_RST = 7'b000_111_0;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [REGW-1:0] id_rs, id_rt, ex_rd;
  logic            id_use_rs, id_use_rt, ex_memread, ex_muldiv, ex_halt, br_taken, resume;
  logic            pc_en, ifid_en, idex_en, ifid_clr, idex_clr, exmem_clr, halted;
  logic [15:0]     stall_cnt, flush_cnt;
  logic [6:0]      outs;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REGW(REGW), .MULDIV_CYC(MULDIV_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_muldiv(ex_muldiv), .ex_halt(ex_halt),
    .br_taken(br_taken), .resume(resume), .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .ifid_clr(ifid_clr), .idex_clr(idex_clr),
    .exmem_clr(exmem_clr), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign outs = {pc_en, ifid_en, idex_en, ifid_clr, idex_clr, exmem_clr, halted};

  task automatic idle_inputs();
    rst_n = 1'b1; id_rs = '0; id_rt = '0; ex_rd = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; ex_memread = 1'b0;
    ex_muldiv = 1'b0; ex_halt = 1'b0; br_taken = 1'b0; resume = 1'b0;
  endtask

  // Inputs change at posedge+1; outputs are sampled at the following negedge.
  task automatic next_edge();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    next_edge(); next_edge();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0; ex_muldiv = 1'b1; br_taken = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (outs !== O_RST) begin n_fail++; $display("FAIL reset_outs got=%b exp=%b", outs, O_RST); end
    next_edge();
    n_cmp++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (outs !== O_DEF) begin n_fail++; $display("FAIL reset_release got=%b exp=%b", outs, O_DEF); end
    next_edge();
  endtask

  task automatic test_load_use();
    apply_reset();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (outs !== O_LU) begin n_fail++; $display("FAIL load_use got=%b exp=%b", outs, O_LU); end
    next_edge();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (outs !== O_DEF || stall_cnt !== 16'd1) begin
      n_fail++; $display("FAIL load_use_after got=%b/%0d exp=%b/1", outs, stall_cnt, O_DEF);
    end
    next_edge();
    ex_memread = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_use_rt = 1'b1; id_rs = 5'd3; id_use_rs = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (outs !== O_LU) begin n_fail++; $display("FAIL load_use_rt got=%b exp=%b", outs, O_LU); end
    next_edge();
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    apply_reset();
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (outs !== O_DEF) begin n_fail++; $display("FAIL zero_reg got=%b exp=%b", outs, O_DEF); end
    next_edge();
    ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (outs !== O_DEF) begin n_fail++; $display("FAIL unused_rs got=%b exp=%b", outs, O_DEF); end
    next_edge();
    n_cmp++;
    if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL zero_reg_cnt got=%0d exp=0", stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_branch_priority();
    apply_reset();
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs = 5'd7; id_use_rs = 1'b1; br_taken = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (outs !== O_BR) begin n_fail++; $display("FAIL branch_vs_lu got=%b exp=%b", outs, O_BR); end
    next_edge();
    idle_inputs();
    n_cmp++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL branch_cnt got=%0d/%0d exp=1/0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_muldiv();
    logic [6:0] exp;
    apply_reset();
    ex_muldiv = 1'b1; br_taken = 1'b1; ex_halt = 1'b1;
    for (int c = 1; c <= MULDIV_CYC; c++) begin
      exp = (c < MULDIV_CYC) ? O_FRZ : O_DEF;
      @(negedge clk);
      n_cmp++;
      if (outs !== exp) begin n_fail++; $display("FAIL muldiv_c%0d got=%b exp=%b", c, outs, exp); end
      next_edge();
    end
    idle_inputs();
    br_taken = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (outs !== O_BR) begin n_fail++; $display("FAIL muldiv_run got=%b exp=%b", outs, O_BR); end
    next_edge();
    idle_inputs();
    n_cmp++;
    if (stall_cnt !== 16'(MULDIV_CYC - 1) || flush_cnt !== 16'd1) begin
      n_fail++; $display("FAIL muldiv_cnt got=%0d/%0d exp=%0d/1", stall_cnt, flush_cnt, MULDIV_CYC - 1);
    end
  endtask

  task automatic test_halt_resume();
    apply_reset();
    ex_halt = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (outs !== O_DEF) begin n_fail++; $display("FAIL halt_entry got=%b exp=%b", outs, O_DEF); end
    next_edge();
    idle_inputs();
    ex_muldiv = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (outs !== O_HLT) begin n_fail++; $display("FAIL halted_c%0d got=%b exp=%b", c, outs, O_HLT); end
      next_edge();
    end
    idle_inputs();
    resume = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (outs !== O_HLT) begin n_fail++; $display("FAIL resume_cyc got=%b exp=%b", outs, O_HLT); end
    next_edge();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (outs !== O_DEF || stall_cnt !== 16'd6) begin
      n_fail++; $display("FAIL after_resume got=%b/%0d exp=%b/6", outs, stall_cnt, O_DEF);
    end
    next_edge();
    ex_muldiv = 1'b1;
    next_edge();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (outs !== O_FRZ) begin n_fail++; $display("FAIL mid_muldiv got=%b exp=%b", outs, O_FRZ); end
    next_edge();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (outs !== O_RST) begin n_fail++; $display("FAIL reset_mid_md got=%b exp=%b", outs, O_RST); end
    next_edge();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (outs !== O_DEF || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      n_fail++; $display("FAIL post_reset_md got=%b/%0d/%0d exp=%b/0/0", outs, stall_cnt, flush_cnt, O_DEF);
    end
    next_edge();
  endtask

  task automatic test_saturation();
    apply_reset();
    ex_halt = 1'b1;
    next_edge();
    idle_inputs();
    repeat (70000) next_edge();
    @(negedge clk);
    n_cmp++;
    if (stall_cnt !== 16'hFFFF || outs !== O_HLT) begin
      n_fail++; $display("FAIL stall_sat got=%h/%b exp=ffff/%b", stall_cnt, outs, O_HLT);
    end
    next_edge();
    n_cmp++;
    if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stall_sat_hold got=%h exp=ffff", stall_cnt); end
    resume = 1'b1;
    next_edge();
    idle_inputs();
  endtask

  // Reference model: tracks "halted", remaining mul/div occupancy cycles and counters.
  task automatic test_random();
    bit         m_halt;
    int         m_busy, m_stall, m_flush;
    logic [6:0] exp;
    bit         lu;
    apply_reset();
    m_halt = 0; m_busy = 0; m_stall = 0; m_flush = 0;
    for (int c = 0; c < 500; c++) begin
      rst_n      = ($urandom_range(0, 39) != 0);
      id_rs      = REGW'($urandom_range(0, 3));
      id_rt      = REGW'($urandom_range(0, 3));
      ex_rd      = REGW'($urandom_range(0, 3));
      id_use_rs  = 1'($urandom_range(0, 1));
      id_use_rt  = 1'($urandom_range(0, 1));
      ex_memread = 1'($urandom_range(0, 1));
      ex_muldiv  = ($urandom_range(0, 7) == 0);
      br_taken   = ($urandom_range(0, 3) == 0);
      ex_halt    = ($urandom_range(0, 15) == 0);
      resume     = ($urandom_range(0, 3) == 0);
      lu = ex_memread && (ex_rd != 0) &&
           ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
      if (!rst_n)          exp = O_RST;
      else if (m_halt)     exp = O_HLT;
      else if (m_busy > 0) exp = (m_busy > 1) ? O_FRZ : O_DEF;
      else if (ex_muldiv)  exp = O_FRZ;
      else if (br_taken)   exp = O_BR;
      else if (lu)         exp = O_LU;
      else                 exp = O_DEF;
      @(negedge clk);
      n_cmp++;
      if (outs !== exp) begin n_fail++; $display("FAIL rand_outs c=%0d got=%b exp=%b", c, outs, exp); end
      if (!rst_n) begin
        m_halt = 0; m_busy = 0; m_stall = 0; m_flush = 0;
      end else begin
        if (exp[6] == 1'b0) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
        if (!m_halt && m_busy == 0 && br_taken && !ex_muldiv)
          m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
        if (m_halt) begin
          if (resume) m_halt = 0;
        end else if (m_busy > 0) m_busy--;
        else if (ex_muldiv) m_busy = MULDIV_CYC - 1;
        else if (ex_halt) m_halt = 1;
      end
      next_edge();
      n_cmp++;
      if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush)) begin
        n_fail++; $display("FAIL rand_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, stall_cnt, flush_cnt, m_stall, m_flush);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    next_edge();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch_priority();
    test_muldiv();
    test_halt_resume();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter REGW, default 5: register-address width.
REQ-002 The block SHALL have parameter MULDIV_CYC, default 4: total cycles a mul/div occupies EX; legal range 2..16.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-004 The block SHALL have port rst_n, input, 1: reset is synchronous and active-low.
REQ-005 The block SHALL have ports id_rs, id_rt, input, REGW each: source registers of the instruction in ID.
REQ-006 The block SHALL have ports id_use_rs, id_use_rt, input, 1 each: ID instruction actually reads rs/rt.
REQ-007 The block SHALL have port ex_rd, input, REGW: destination register of the instruction in EX.
REQ-008 The block SHALL have ports ex_memread, ex_muldiv, ex_halt, input, 1 each: EX instruction is a load / mul-div / halt.
REQ-009 The block SHALL have port br_taken, input, 1: branch/jump resolved taken in EX.
REQ-010 The block SHALL have port resume, input, 1: leave halt state.
REQ-011 The block SHALL have ports pc_en, ifid_en, idex_en, output, 1 each: pipeline register enables.
REQ-012 The block SHALL have ports ifid_clr, idex_clr, exmem_clr, output, 1 each: pipeline register clears (bubble insert).
REQ-013 The block SHALL have port halted, output, 1: state is HALT.
REQ-014 The block SHALL have ports stall_cnt, flush_cnt, output, 16 each: saturating event counters.

Function
REQ-015 The block SHALL implement states RUN, MULDIV, HALT plus a 4-bit down-counter md_cnt; enable/clear outputs are combinational from state and inputs.
REQ-016 Default (RUN, no hazard) outputs SHALL be: all enables 1, all clears 0.
REQ-017 Load-use hazard SHALL be: ex_memread=1, ex_rd!=0, and ((id_use_rs and id_rs==ex_rd) or (id_use_rt and id_rt==ex_rd)).
REQ-018 In RUN, load-use SHALL give pc_en=0, ifid_en=0, idex_clr=1, others default (one bubble, one cycle).
REQ-019 In RUN, br_taken=1 SHALL give ifid_clr=1, idex_clr=1, enables 1; br_taken has priority over load-use.
REQ-020 In RUN, ex_muldiv=1 SHALL freeze (pc_en=ifid_en=idex_en=0, exmem_clr=1, other clears 0), load md_cnt=MULDIV_CYC-2, and go MULDIV; ex_muldiv has priority over br_taken, load-use and ex_halt.
REQ-021 In MULDIV with md_cnt!=0 the block SHALL freeze and decrement md_cnt; with md_cnt==0 it SHALL output defaults and go RUN; ex_muldiv, br_taken, load-use, ex_halt are ignored in MULDIV.
REQ-022 Total freeze per mul/div SHALL be exactly MULDIV_CYC-1 cycles; pipeline advances on cycle MULDIV_CYC.
REQ-023 In RUN, ex_halt=1 (ex_muldiv=0) SHALL produce RUN outputs that cycle (br_taken/load-use still apply) and go HALT next edge.
REQ-024 In HALT the block SHALL output pc_en=ifid_en=idex_en=0, all clears 0, halted=1; resume=1 returns to RUN next edge; resume ignored outside HALT.
REQ-025 stall_cnt SHALL increment on each posedge where pc_en==0 and rst_n==1 (includes load-use, MULDIV freeze, HALT); saturates at 0xFFFF.
REQ-026 flush_cnt SHALL increment on each posedge where RUN, br_taken=1, ex_muldiv=0; saturates at 0xFFFF.

Reset
REQ-027 While rst_n=0, outputs SHALL be pc_en=ifid_en=idex_en=0, ifid_clr=idex_clr=exmem_clr=1, halted=0, regardless of state.
REQ-028 On posedge with rst_n=0, state SHALL become RUN, md_cnt=0, stall_cnt=0, flush_cnt=0, including mid-MULDIV or HALT.
REQ-029 Counters SHALL not increment on a reset edge.

Verification
REQ-030 Load-use: ex_memread=1, ex_rd=5, id_rs=5, id_use_rs=1 one cycle -> pc_en=0, ifid_en=0, idex_clr=1 that cycle only; stall_cnt 0->1.
REQ-031 Zero-reg/unused: same as REQ-030 with ex_rd=0, then ex_rd=5 with id_use_rs=0 -> no stall, outputs default.
REQ-032 Branch vs load-use: br_taken=1 with load-use true -> ifid_clr=idex_clr=1, pc_en=1; flush_cnt=1, stall_cnt=0.
REQ-033 Mul/div MULDIV_CYC=4: ex_muldiv=1 held 4 cycles -> freeze cycles 1-3 with exmem_clr=1, defaults cycle 4, RUN after; stall_cnt=3.
REQ-034 Halt/resume/reset: ex_halt=1 -> halted=1 from next cycle, pc_en=0; resume after 5 cycles -> RUN; rst_n=0 mid-MULDIV -> RUN, counters 0 next edge.
REQ-035 Saturation: hold HALT 70000 cycles -> stall_cnt stays 0xFFFF.
